alu_share_arbiter: RTL and testbench

//  Shares one 32-bit ALU instance between NUM_REQ requesters (e.g. execute stage, address-gen, CSR unit).

---
 rtl/alu_pkg.sv | 23 ++
 rtl/ALU.sv | 31 +++
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU share arbiter: ALU opcodes and arbiter FSM states.
// Pure declarations, no logic; imported by the arbiter and the ALU.
// Opcodes above ALU_XOR are legal on the wire and behave as ALU_ADD.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR/XOR, unknown opcodes fall back to ADD.
// Latency: zero cycles, purely combinational.
// Backpressure: none; results follow the inputs every cycle.
module ALU
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [OP_W-1:0]   ALU_operation,
   output logic [DATA_W-1:0] ALU_result,
   output logic              zero
);

   // Operation select; wrap-around arithmetic, carry out is dropped.
   always_comb begin
      ALU_result = A + B;
      case (ALU_operation)
         ALU_SUB: ALU_result = A - B;
         ALU_AND: ALU_result = A & B;
         ALU_OR:  ALU_result = A | B;
         ALU_XOR: ALU_result = A ^ B;
         default: ALU_result = A + B;
      endcase
   end

   // Equality flag, independent of the selected operation.
   always_comb begin
      zero = (A == B);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU among NUM_REQ valid/ready requesters, tagged registered response.
// Latency: request accepted in cycle T gives rsp_valid in cycle T+2; one op per 3 cycles at best.
// Backpressure: response held stable while rsp_ready=0; no new request accepted until it drains.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [OP_W*NUM_REQ-1:0]   req_op,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero
);

   // FSM and round-robin pointer
   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

   // Captured request; the ALU only ever sees these registers
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [ID_W-1:0]   id_q, id_d;

   // Registered response
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;

   // Arbitration
   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_oh;
   int                grant_sum;
   logic [ID_W-1:0]   grant_try;
   logic              accept;

   // ALU outputs
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   // Round-robin search starting at rr_ptr; scanning from the far end lets the
   // closest valid requester (smallest offset) be the last one written.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_sum = 0;
      grant_try = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         grant_sum = (int'(rr_ptr_q) + k) % NUM_REQ;
         grant_try = ID_W'(grant_sum);
         if (req_valid[grant_try]) begin
            grant_vld = 1'b1;
            grant_idx = grant_try;
         end
      end
   end

   // One-hot form of the winner, used directly as the ready vector.
   always_comb begin
      grant_oh = '0;
      grant_oh[grant_idx] = grant_vld;
   end

   // Ready only in IDLE and never while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == IDLE)) begin
         req_ready = grant_oh;
      end
      accept = rst_n && (state_q == IDLE) && grant_vld;
   end

   // Next-state, operand capture and response register update.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (grant_idx == ID_W'(i)) begin
                     op_d = req_op[OP_W*i +: OP_W];
                     a_d  = req_a[DATA_W*i +: DATA_W];
                     b_d  = req_b[DATA_W*i +: DATA_W];
                  end
               end
               id_d    = grant_idx;
               state_d = EXEC;
               // Pointer moves just past the winner so it becomes lowest priority.
               if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_idx + ID_W'(1);
               end
            end
         end

         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State registers; reset throws away any captured operands and pending response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   ALU u_alu (
      .A             (a_q),
      .B             (b_q),
      .ALU_operation (op_q),
      .ALU_result    (alu_result),
      .zero          (alu_zero)
   );

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with two requesters: directed scenarios plus random traffic.
// Expected grants come from a rotating-priority model, expected results from plain arithmetic.
module tb_alu_share_arbiter;

   localparam int N  = 2;
   localparam int IW = 1;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [4*N-1:0]  req_op;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [31:0]     rsp_result;
   logic            rsp_zero;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int m_ptr   = 0;

   logic [3:0]  m_op [N];
   logic [31:0] m_a  [N];
   logic [31:0] m_b  [N];

   alu_share_arbiter #(.NUM_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a + b;
      endcase
   endfunction

   // Requester with highest priority: first valid one counting up from ptr, wrapping.
   function automatic int ref_grant(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*r +: 4]  = op;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      m_op[r] = op;
      m_a[r]  = a;
      m_b[r]  = b;
   endtask

   // Returns the ready vector of the first cycle in which any ready is seen.
   task automatic wait_ready(output logic [N-1:0] mask, output int c, output bit to);
      to = 1'b1; mask = '0; c = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req_ready != '0) begin
            mask = req_ready; c = cyc; to = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output int c, output bit to);
      to = 1'b1; c = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rsp_valid === 1'b1) begin
            c = cyc; to = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Issues one request from requester r alone and lets the response drain (rsp_ready must be 1).
   task automatic drive_single(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [N-1:0] mask, output int lat, output bit to,
                               output logic [31:0] res, output logic z, output logic [IW-1:0] id);
      int ca, cr;
      bit t1, t2;
      set_req(r, op, a, b);
      req_valid = N'(1) << r;
      wait_ready(mask, ca, t1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(cr, t2);
      to  = t1 | t2;
      lat = cr - ca;
      res = rsp_result;
      z   = rsp_zero;
      id  = rsp_id;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
      set_req(0, 4'd0, 32'h11, 32'h22);
      set_req(1, 4'd1, 32'h33, 32'h44);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
         n_tests++;
         if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
      end
      n_tests++;
      if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h exp 0", rsp_result); end
      n_tests++;
      if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %h exp 0", rsp_id); end
      n_tests++;
      if (rsp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_zero: got %b exp 0", rsp_zero); end
      req_valid = '0; rst_n = 1'b1; m_ptr = 0;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
         n_fail++; $display("FAIL post_reset_idle: rsp_valid=%b req_ready=%b exp 0/00", rsp_valid, req_ready);
      end
   endtask

   task automatic test_single_op();
      logic [N-1:0] mask; int lat; bit to; logic [31:0] res; logic z; logic [IW-1:0] id;
      int g;
      rsp_ready = 1'b1;
      g = ref_grant(2'b01, m_ptr);
      drive_single(0, 4'd0, 32'h7, 32'h5, mask, lat, to, res, z, id);
      m_ptr = (g + 1) % N;
      n_tests++;
      if (to) begin n_fail++; $display("FAIL single_timeout: handshake or response not seen"); end
      n_tests++;
      if (mask !== (N'(1) << g)) begin n_fail++; $display("FAIL single_grant: got %b exp %b", mask, N'(1) << g); end
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d exp 2", lat); end
      n_tests++;
      if (res !== ref_alu(4'd0, 32'h7, 32'h5)) begin n_fail++; $display("FAIL single_result: got %h exp %h", res, ref_alu(4'd0, 32'h7, 32'h5)); end
      n_tests++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL single_zero: got %b exp 0", z); end
      n_tests++;
      if (id !== IW'(0)) begin n_fail++; $display("FAIL single_id: got %0d exp 0", id); end
      n_tests++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop: rsp_valid got %b exp 0", rsp_valid); end
   endtask

   task automatic test_wrap_zero();
      logic [3:0]  ops [3] = '{4'd1, 4'd1, 4'hF};
      logic [31:0] as  [3] = '{32'h0, 32'h1234, 32'h2};
      logic [31:0] bs  [3] = '{32'h1, 32'h1234, 32'h3};
      logic [N-1:0] mask; int lat; bit to; logic [31:0] res; logic z; logic [IW-1:0] id;
      int g;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         g = ref_grant(2'b10, m_ptr);
         drive_single(1, ops[i], as[i], bs[i], mask, lat, to, res, z, id);
         m_ptr = (g + 1) % N;
         n_tests++;
         if (to) begin n_fail++; $display("FAIL wrap_timeout[%0d]", i); end
         n_tests++;
         if (res !== ref_alu(ops[i], as[i], bs[i])) begin
            n_fail++; $display("FAIL wrap_result[%0d]: got %h exp %h", i, res, ref_alu(ops[i], as[i], bs[i]));
         end
         n_tests++;
         if (z !== (as[i] == bs[i])) begin n_fail++; $display("FAIL wrap_zero[%0d]: got %b exp %b", i, z, as[i] == bs[i]); end
         n_tests++;
         if (id !== IW'(g)) begin n_fail++; $display("FAIL wrap_id[%0d]: got %0d exp %0d", i, id, g); end
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] mask; int lat; bit to; logic [31:0] res; logic z; logic [IW-1:0] id;
      int ca, cr, prev, g;
      rsp_ready = 1'b1;
      set_req(0, 4'd0, 32'h100, 32'h1);
      set_req(1, 4'd2, 32'hF0F0, 32'hFF00);
      req_valid = 2'b11;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         g = ref_grant(2'b11, m_ptr);
         wait_ready(mask, ca, to);
         n_tests++;
         if (to) begin n_fail++; $display("FAIL fair_timeout[%0d]", k); end
         n_tests++;
         if (mask !== (N'(1) << g)) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b exp %b", k, mask, N'(1) << g); end
         if (k > 0) begin
            n_tests++;
            if (ca - prev !== 3) begin n_fail++; $display("FAIL fair_spacing[%0d]: got %0d exp 3", k, ca - prev); end
         end
         prev = ca;
         m_ptr = (g + 1) % N;
         wait_rsp(cr, to);
         n_tests++;
         if (rsp_id !== IW'(g) || rsp_result !== ref_alu(m_op[g], m_a[g], m_b[g])) begin
            n_fail++; $display("FAIL fair_rsp[%0d]: id=%0d res=%h exp id=%0d res=%h", k, rsp_id, rsp_result, g, ref_alu(m_op[g], m_a[g], m_b[g]));
         end
      end
      req_valid = 2'b01;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         g = ref_grant(2'b01, m_ptr);
         drive_single(0, 4'd3, 32'hA0 + k, 32'h0C, mask, lat, to, res, z, id);
         m_ptr = (g + 1) % N;
         n_tests++;
         if (to || mask !== (N'(1) << g)) begin n_fail++; $display("FAIL fair_wrap[%0d]: got %b exp %b to=%0d", k, mask, N'(1) << g, to); end
         n_tests++;
         if (res !== ref_alu(4'd3, 32'hA0 + k, 32'h0C)) begin n_fail++; $display("FAIL fair_wrap_res[%0d]: got %h", k, res); end
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] mask; int ca, cr; bit to; int g;
      logic [31:0] exp_res; logic exp_z;
      rsp_ready = 1'b0;
      set_req(0, 4'd1, 32'h10, 32'h3);
      set_req(1, 4'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
      req_valid = 2'b11;
      g = ref_grant(2'b11, m_ptr);
      wait_ready(mask, ca, to);
      n_tests++;
      if (to || mask !== (N'(1) << g)) begin n_fail++; $display("FAIL bp_grant: got %b exp %b", mask, N'(1) << g); end
      m_ptr = (g + 1) % N;
      exp_res = ref_alu(m_op[g], m_a[g], m_b[g]);
      exp_z   = (m_a[g] == m_b[g]);
      wait_rsp(cr, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL bp_timeout: no response"); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_id !== IW'(g) || rsp_zero !== exp_z) begin
            n_fail++; $display("FAIL bp_hold[%0d]: v=%b res=%h id=%0d z=%b exp 1/%h/%0d/%b", i, rsp_valid, rsp_result, rsp_id, rsp_zero, exp_res, g, exp_z);
         end
         n_tests++;
         if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b exp 00", i, req_ready); end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      g = ref_grant(2'b11, m_ptr);
      n_tests++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: rsp_valid got %b exp 0", rsp_valid); end
      n_tests++;
      if (req_ready !== (N'(1) << g)) begin n_fail++; $display("FAIL bp_next_grant: got %b exp %b", req_ready, N'(1) << g); end
      m_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = '0;
      wait_rsp(cr, to);
      n_tests++;
      if (to || rsp_result !== ref_alu(m_op[g], m_a[g], m_b[g]) || rsp_id !== IW'(g)) begin
         n_fail++; $display("FAIL bp_second: res=%h id=%0d exp %h/%0d", rsp_result, rsp_id, ref_alu(m_op[g], m_a[g], m_b[g]), g);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      logic [N-1:0] mask; int ca, cr; bit to; int g;
      for (int phase = 0; phase < 2; phase++) begin
         rsp_ready = (phase == 0);
         set_req(0, 4'd0, 32'h55 + phase, 32'h66);
         req_valid = 2'b01;
         g = ref_grant(2'b01, m_ptr);
         wait_ready(mask, ca, to);
         n_tests++;
         if (to || mask !== (N'(1) << g)) begin n_fail++; $display("FAIL rst_mid_grant[%0d]: got %b exp %b", phase, mask, N'(1) << g); end
         m_ptr = (g + 1) % N;
         @(negedge clk);
         req_valid = '0;
         if (phase == 1) begin
            wait_rsp(cr, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL rst_mid_resp_timeout"); end
         end
         rst_n = 1'b0;
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b0 || req_ready !== '0 || rsp_result !== 32'h0 || rsp_id !== '0 || rsp_zero !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_clear[%0d]: v=%b rdy=%b res=%h id=%0d z=%b exp all zero", phase, rsp_valid, req_ready, rsp_result, rsp_id, rsp_zero);
         end
         rst_n = 1'b1; rsp_ready = 1'b1; m_ptr = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale[%0d.%0d]: rsp_valid got %b exp 0", phase, i, rsp_valid); end
         end
         set_req(0, 4'd2, 32'hFFFF_0000, 32'h1234_5678);
         set_req(1, 4'd3, 32'h1, 32'h2);
         req_valid = 2'b11;
         g = ref_grant(2'b11, m_ptr);
         wait_ready(mask, ca, to);
         n_tests++;
         if (to || mask !== (N'(1) << g)) begin n_fail++; $display("FAIL rst_mid_ptr[%0d]: got %b exp %b", phase, mask, N'(1) << g); end
         m_ptr = (g + 1) % N;
         @(negedge clk);
         req_valid = '0;
         wait_rsp(cr, to);
         n_tests++;
         if (to || rsp_result !== ref_alu(m_op[g], m_a[g], m_b[g]) || rsp_id !== IW'(g)) begin
            n_fail++; $display("FAIL rst_mid_after[%0d]: res=%h id=%0d exp %h/%0d", phase, rsp_result, rsp_id, ref_alu(m_op[g], m_a[g], m_b[g]), g);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] mask, v; int ca, cr, g, hold; bit to;
      logic [31:0] exp_res; logic exp_z;
      for (int it = 0; it < 40; it++) begin
         for (int r = 0; r < N; r++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_req(r, 4'($urandom_range(0, 15)), a, b);
         end
         v = N'($urandom_range(1, (1 << N) - 1));
         rsp_ready = 1'b0;
         req_valid = v;
         g = ref_grant(v, m_ptr);
         wait_ready(mask, ca, to);
         n_tests++;
         if (to || mask !== (N'(1) << g)) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b exp %b v=%b", it, mask, N'(1) << g, v); end
         m_ptr = (g + 1) % N;
         exp_res = ref_alu(m_op[g], m_a[g], m_b[g]);
         exp_z   = (m_a[g] == m_b[g]);
         @(negedge clk);
         req_valid = '0;
         wait_rsp(cr, to);
         n_tests++;
         if (to || cr - ca !== 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d exp 2 to=%0d", it, cr - ca, to); end
         n_tests++;
         if (rsp_result !== exp_res || rsp_zero !== exp_z || rsp_id !== IW'(g)) begin
            n_fail++; $display("FAIL rand_rsp[%0d]: res=%h z=%b id=%0d exp %h/%b/%0d", it, rsp_result, rsp_zero, rsp_id, exp_res, exp_z, g);
         end
         hold = $urandom_range(0, 2);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res) begin
               n_fail++; $display("FAIL rand_hold[%0d]: v=%b res=%h exp 1/%h", it, rsp_valid, rsp_result, exp_res);
            end
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain[%0d]: rsp_valid got %b exp 0", it, rsp_valid); end
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      req_op = '0; req_a = '0; req_b = '0;
      test_reset();
      test_single_op();
      test_wrap_zero();
      test_fairness();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
